// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the parity-frame receiver.
// Also holds the saturating increment used by the optional error counter.
package parity_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int          ERR_CNT_W   = 8;
   localparam int unsigned ERR_CNT_MAX = 255;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(
      input logic [ERR_CNT_W-1:0] v
   );
      if (v == ERR_CNT_W'(ERR_CNT_MAX))
         return v;
      return v + 1'b1;
   endfunction

endpackage

// File: rtl/parity_rx_if.sv
// Serial-in / word-out bundle of the parity receiver.
// master drives the bit stream, slave is the receiver.
interface parity_rx_if #(
   parameter int DATA_W = 8
);

   logic              bit_in;
   logic              bit_valid;
   logic              abort;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              busy;

   modport master (
      output bit_in,
      output bit_valid,
      output abort,
      input  data_out,
      input  data_valid,
      input  parity_err,
      input  busy
   );

   modport slave (
      input  bit_in,
      input  bit_valid,
      input  abort,
      output data_out,
      output data_valid,
      output parity_err,
      output busy
   );

endinterface

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator with clear and enable.
// clr with en loads d directly so a frame's first bit seeds the sum.
module parity_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= 1'b0;
      else if (clr)
         q <= en & d;
      else if (en)
         q <= q ^ d;
   end

endmodule

// File: rtl/parity_rx.sv
// Serial parity-frame receiver: DATA_W bits LSB first, then one parity bit.
// Optional saturating error counter enabled by PARITY_RX_ERR_CNT_EN.
module parity_rx
   import parity_rx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   parity_rx_if.slave rx
`ifdef PARITY_RX_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_count
`endif
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   state_t            state_q;
   state_t            state_d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              perr_q;
   logic              data_acc;
   logic              par_acc;
   logic              acc;
   logic              err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // abort has priority over a coincident bit strobe
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_acc = 1'b0;
      par_acc  = 1'b0;
      if (rx.abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (rx.bit_valid) begin
         unique case (state_q)
            IDLE, DATA: begin
               data_acc = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               state_d  = (cnt_q == LAST) ? PARITY : DATA;
            end
            PARITY: begin
               par_acc = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   parity_acc u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == IDLE),
      .en    (data_acc),
      .d     (rx.bit_in),
      .q     (acc)
   );

   assign err = acc ^ rx.bit_in ^ ODD_PARITY;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else if (data_acc) begin
         for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CW'(i))
               shift_q[i] <= rx.bit_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         valid_q <= par_acc;
         if (par_acc) begin
            data_q <= shift_q;
            perr_q <= err;
         end
      end
   end

   assign rx.data_out   = data_q;
   assign rx.data_valid = valid_q;
   assign rx.parity_err = perr_q;
   assign rx.busy       = (state_q != IDLE);

`ifdef PARITY_RX_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (par_acc && err)
         err_count <= sat_inc(err_count);
   end
`endif

endmodule
